// File: rtl/ldd_wdis_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldd_wdis_seq_pkg                                              |
// | Purpose  : Definitions shared by the LDD write-disable blocks: channel    |
// |            state encoding, default timing values, and the counter-width  |
// |            helper.                                                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
package ldd_wdis_seq_pkg;

  // Per-channel guard states.
  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } ch_state_e;

  // Default timing, shared with the other LDD blocks.
  localparam int DEF_MIN_ON    = 4;
  localparam int DEF_MIN_OFF   = 3;
  localparam int DEF_BLANK_CYC = 8;

  // Width needed to hold the largest timing value; never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldd_wdis_seq_ch_guard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldd_ch_guard                                                  |
// | Purpose  : One LDD channel: OFF/ON state machine enforcing minimum       |
// |            on-time and off-time, immediate kill / forced-off, and the    |
// |            sticky short-pulse flag.                                      |
// | Ports    : clk_i, rst_ni    - clock, async active-low reset              |
// |            req_i            - write request (already source-selected)    |
// |            kill_i           - fault kill, forces OFF                     |
// |            force_off_i      - source-switch force, forces OFF            |
// |            hold_off_i       - blank window active, blocks turn-on        |
// |            clr_short_i      - clears short_flag_o (a new set wins)       |
// |            en_o / en_d_o    - current / next enable state                |
// |            short_flag_o     - ON pulse was cut before MIN_ON             |
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
module ldd_ch_guard
  import ldd_wdis_seq_pkg::*;
#(
  parameter int MIN_ON  = DEF_MIN_ON,
  parameter int MIN_OFF = DEF_MIN_OFF,
  parameter int CW      = cnt_width(DEF_MIN_ON, DEF_MIN_OFF, 0)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic kill_i,
  input  logic force_off_i,
  input  logic hold_off_i,
  input  logic clr_short_i,
  output logic en_o,
  output logic en_d_o,
  output logic short_flag_o
);

  localparam logic [CW-1:0] ON_MAX  = CW'(MIN_ON);
  localparam logic [CW-1:0] OFF_MAX = CW'(MIN_OFF);

  ch_state_e     state_q, state_d;
  logic [CW-1:0] on_cnt_q, on_cnt_d;
  logic [CW-1:0] off_cnt_q, off_cnt_d;
  logic          short_q, short_d;
  logic          short_set;
  logic [CW-1:0] on_inc;
  logic [CW-1:0] off_inc;
  logic          force_off;

  // The incremented value counts the current cycle, so comparing it against
  // the minimum gives "cycles spent in this state including this one".
  assign on_inc    = (on_cnt_q  >= ON_MAX)  ? ON_MAX  : on_cnt_q  + CW'(1);
  assign off_inc   = (off_cnt_q >= OFF_MAX) ? OFF_MAX : off_cnt_q + CW'(1);
  assign force_off = kill_i | force_off_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OFF;
      on_cnt_q  <= '0;
      off_cnt_q <= OFF_MAX;  // saturated: may enable right after reset
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      short_q   <= short_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    short_set = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (force_off) begin
          // Held off: the off-time restarts once the kill/force releases.
          off_cnt_d = '0;
        end else begin
          off_cnt_d = off_inc;
          if (req_i && (off_inc >= OFF_MAX) && !hold_off_i) begin
            state_d  = ST_ON;
            on_cnt_d = '0;
          end
        end
      end
      ST_ON: begin
        if (force_off) begin
          state_d   = ST_OFF;
          off_cnt_d = '0;
          short_set = (on_inc < ON_MAX);
        end else begin
          on_cnt_d = on_inc;
          if (!req_i && (on_inc >= ON_MAX)) begin
            state_d   = ST_OFF;
            off_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Set has priority over a same-cycle clear.
    short_d = (short_q & ~clr_short_i) | short_set;
  end

  assign en_o         = (state_q == ST_ON);
  assign en_d_o       = (state_d == ST_ON);
  assign short_flag_o = short_q;

endmodule
`default_nettype wire

// File: rtl/ldd_wdis_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldd_wdis_seq                                                  |
// | Purpose  : LDD write-disable output stage. Selects per-channel write     |
// |            requests from the capture or communication source, applies   |
// |            per-channel minimum on/off times, blanks all channels after   |
// |            a source switch, and drives polarity-configurable enables.    |
// | Ports    : clk200_i       - 200 MHz system clock                         |
// |            rst_ni         - async active-low reset                       |
// |            cap_mode_i     - 1 = capture source, 0 = communication        |
// |            cap_wdis_i     - capture write-disable (request = ~wdis)      |
// |            com_wdis_i     - communication write-disable                  |
// |            kill_i         - per-channel fault kill                       |
// |            clr_short_i    - clears short_flag_o                          |
// |            ldd_en_o       - true enable per channel                      |
// |            ldd_out_o      - pad-side drive (inverted if OUT_ACT_LOW)     |
// |            blanking_o     - blank window active                          |
// |            short_flag_o   - sticky short-pulse flags                     |
// | Revision : 1.0 - initial parametrised release                            |
// +--------------------------------------------------------------------------+
module ldd_wdis_seq
  import ldd_wdis_seq_pkg::*;
#(
  parameter int CH          = 3,
  parameter int MIN_ON      = DEF_MIN_ON,
  parameter int MIN_OFF     = DEF_MIN_OFF,
  parameter int BLANK_CYC   = DEF_BLANK_CYC,
  parameter bit OUT_ACT_LOW = 1'b1
) (
  input  logic          clk200_i,
  input  logic          rst_ni,
  input  logic          cap_mode_i,
  input  logic [CH-1:0] cap_wdis_i,
  input  logic [CH-1:0] com_wdis_i,
  input  logic [CH-1:0] kill_i,
  input  logic          clr_short_i,
  output logic [CH-1:0] ldd_en_o,
  output logic [CH-1:0] ldd_out_o,
  output logic          blanking_o,
  output logic [CH-1:0] short_flag_o
);

  localparam int            CW      = cnt_width(MIN_ON, MIN_OFF, BLANK_CYC);
  localparam logic [CH-1:0] OUT_POL = {CH{OUT_ACT_LOW}};

  logic          init_q;
  logic          mode_q;
  logic [CW-1:0] blank_cnt_q, blank_cnt_d;
  logic [CH-1:0] out_q;
  logic          switch_ev;
  logic          blank_active;
  logic [CH-1:0] req;
  logic [CH-1:0] en_d;

  // The first edge after reset only captures the mode; it is not a switch.
  assign switch_ev    = !init_q && (cap_mode_i != mode_q);
  assign blank_active = (blank_cnt_q != '0);
  assign req          = cap_mode_i ? ~cap_wdis_i : ~com_wdis_i;

  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (switch_ev) begin
      blank_cnt_d = CW'(BLANK_CYC);
    end else if (blank_active) begin
      blank_cnt_d = blank_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk200_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q      <= 1'b1;
      mode_q      <= 1'b0;
      blank_cnt_q <= '0;
      out_q       <= OUT_POL;
    end else begin
      init_q      <= 1'b0;
      mode_q      <= cap_mode_i;
      blank_cnt_q <= blank_cnt_d;
      // Pad drive is taken from the next-state enable so it lands on the
      // same edge as ldd_en_o.
      out_q       <= en_d ^ OUT_POL;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    ldd_ch_guard #(
      .MIN_ON  (MIN_ON),
      .MIN_OFF (MIN_OFF),
      .CW      (CW)
    ) u_guard (
      .clk_i        (clk200_i),
      .rst_ni       (rst_ni),
      .req_i        (req[i]),
      .kill_i       (kill_i[i]),
      .force_off_i  (switch_ev),
      .hold_off_i   (blank_active),
      .clr_short_i  (clr_short_i),
      .en_o         (ldd_en_o[i]),
      .en_d_o       (en_d[i]),
      .short_flag_o (short_flag_o[i])
    );
  end

  assign ldd_out_o  = out_q;
  assign blanking_o = blank_active;

endmodule
`default_nettype wire

// File: tb/tb_ldd_wdis_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ldd_wdis_seq                                               |
// | Purpose  : Self-checking bench for ldd_wdis_seq. A reference model       |
// |            tracks each channel's enable and elapsed time in its state;   |
// |            expected outputs are queued on every edge and compared by an  |
// |            independent monitor on the falling edge.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ldd_wdis_seq;

  localparam int CH          = 3;
  localparam int MIN_ON      = 4;
  localparam int MIN_OFF     = 3;
  localparam int BLANK_CYC   = 8;
  localparam bit OUT_ACT_LOW = 1'b1;

  typedef struct packed {
    logic [CH-1:0] en;
    logic [CH-1:0] out;
    logic          blank;
    logic [CH-1:0] sh;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_mode = 1'b0;
  logic [CH-1:0] cap_wdis = '1;
  logic [CH-1:0] com_wdis = '1;
  logic [CH-1:0] kill = '0;
  logic          clr_short = 1'b0;
  logic [CH-1:0] ldd_en;
  logic [CH-1:0] ldd_out;
  logic          blanking;
  logic [CH-1:0] short_flag;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q[$];

  // Reference model state: enable, cycles elapsed since entering the state,
  // sticky flag, captured mode, blank cycles remaining.
  bit m_en[CH];
  int m_age[CH];
  bit m_sh[CH];
  bit m_mode;
  int m_blank;
  bit m_init;

  always #5 clk = ~clk;

  ldd_wdis_seq #(
    .CH          (CH),
    .MIN_ON      (MIN_ON),
    .MIN_OFF     (MIN_OFF),
    .BLANK_CYC   (BLANK_CYC),
    .OUT_ACT_LOW (OUT_ACT_LOW)
  ) dut (
    .clk200_i     (clk),
    .rst_ni       (rst_n),
    .cap_mode_i   (cap_mode),
    .cap_wdis_i   (cap_wdis),
    .com_wdis_i   (com_wdis),
    .kill_i       (kill),
    .clr_short_i  (clr_short),
    .ldd_en_o     (ldd_en),
    .ldd_out_o    (ldd_out),
    .blanking_o   (blanking),
    .short_flag_o (short_flag)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_en[i]  = 1'b0;
      m_age[i] = 1000;  // long idle: free to enable at once
      m_sh[i]  = 1'b0;
    end
    m_blank = 0;
    m_init  = 1'b1;
    q.delete();
  endtask

  task automatic model_step();
    bit   sw;
    bit   ba;
    bit   rq;
    bit   kl;
    bit   set;
    exp_t e;
    if (m_init) begin
      sw     = 1'b0;
      m_init = 1'b0;
    end else begin
      sw = (cap_mode != m_mode);
    end
    m_mode = cap_mode;
    ba     = (m_blank > 0);
    for (int i = 0; i < CH; i++) begin
      rq  = cap_mode ? !cap_wdis[i] : !com_wdis[i];
      kl  = kill[i] || sw;
      set = 1'b0;
      if (m_en[i]) begin
        if (kl) begin
          set      = (m_age[i] + 1 < MIN_ON);
          m_en[i]  = 1'b0;
          m_age[i] = 0;
        end else if (!rq && (m_age[i] + 1 >= MIN_ON)) begin
          m_en[i]  = 1'b0;
          m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
      end else begin
        if (kl) begin
          m_age[i] = 0;
        end else if (rq && (m_age[i] + 1 >= MIN_OFF) && !ba) begin
          m_en[i]  = 1'b1;
          m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
      end
      m_sh[i] = (clr_short ? 1'b0 : m_sh[i]) | set;
    end
    if (sw) m_blank = BLANK_CYC;
    else if (ba) m_blank--;
    for (int i = 0; i < CH; i++) begin
      e.en[i]  = m_en[i];
      e.out[i] = OUT_ACT_LOW ? !m_en[i] : m_en[i];
      e.sh[i]  = m_sh[i];
    end
    e.blank = (m_blank > 0);
    q.push_back(e);
  endtask

  // One clock edge: DUT and model both see the current inputs; returns 1
  // time unit later so the caller can change inputs away from the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        check("mon_en",    8'(ldd_en),     8'(e.en));
        check("mon_out",   8'(ldd_out),    8'(e.out));
        check("mon_blank", 8'(blanking),   8'(e.blank));
        check("mon_short", 8'(short_flag), 8'(e.sh));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_en",    8'(ldd_en),     8'h00);
    check("rst_out",   8'(ldd_out),    8'h07);
    check("rst_blank", 8'(blanking),   8'h00);
    check("rst_short", 8'(short_flag), 8'h00);
    #1 rst_n = 1'b1;

    // Communication source, channel 0 requested.
    com_wdis = 3'b110;
    tick();
    check("first_en",    8'(ldd_en),   8'h01);
    check("first_out",   8'(ldd_out),  8'h06);
    check("first_blank", 8'(blanking), 8'h00);

    // Request drops after one cycle: enable held for 4 cycles total.
    com_wdis = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("minon_hold", 8'(ldd_en[0]), 8'h01);
    end
    tick();
    check("minon_drop",  8'(ldd_en[0]),     8'h00);
    check("minon_short", 8'(short_flag[0]), 8'h00);

    // Request returns at once: re-assert deferred to the 3rd off cycle.
    com_wdis = 3'b110;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("minoff_hold", 8'(ldd_en[0]), 8'h00);
    end
    tick();
    check("minoff_rise", 8'(ldd_en[0]), 8'h01);

    // Channel 1 on for two cycles, then killed.
    com_wdis = 3'b100;
    tick();
    check("ch1_on", 8'(ldd_en[1]), 8'h01);
    tick();
    kill = 3'b010;
    tick();
    check("kill_en",    8'(ldd_en[1]),     8'h00);
    check("kill_short", 8'(short_flag[1]), 8'h01);
    kill      = '0;
    clr_short = 1'b1;
    tick();
    check("clr_short", 8'(short_flag[1]), 8'h00);
    clr_short = 1'b0;

    // Source switch with every request active.
    cap_wdis = '0;
    com_wdis = '0;
    repeat (6) tick();
    cap_mode = 1'b1;
    tick();
    check("sw_en",    8'(ldd_en),   8'h00);
    check("sw_blank", 8'(blanking), 8'h01);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("blank_on", 8'(blanking), 8'h01);
      check("blank_en", 8'(ldd_en),   8'h00);
    end
    tick();
    check("blank_end", 8'(blanking), 8'h00);
    tick();
    check("post_blank_en", 8'(ldd_en), 8'h07);

    // Second switch at blank cycle 5 restarts the full window.
    cap_mode = 1'b0;
    tick();
    repeat (4) tick();
    cap_mode = 1'b1;
    tick();
    check("reload_blank", 8'(blanking), 8'h01);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("reload_hold", 8'(blanking), 8'h01);
    end
    tick();
    check("reload_end", 8'(blanking), 8'h00);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) cap_wdis = 3'($urandom);
      if ($urandom_range(3) == 0) com_wdis = 3'($urandom);
      kill      = ($urandom_range(15) == 0) ? 3'($urandom) : 3'b000;
      clr_short = ($urandom_range(15) == 0);
      if ($urandom_range(49) == 0) cap_mode = ~cap_mode;
      tick();
    end

    // Asynchronous reset while channels are on.
    kill      = '0;
    clr_short = 1'b0;
    cap_wdis  = '0;
    com_wdis  = '0;
    repeat (14) tick();
    check("pre_rst_en", 8'(ldd_en), 8'h07);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out",   8'(ldd_out),    8'h07);
    check("arst_en",    8'(ldd_en),     8'h00);
    check("arst_blank", 8'(blanking),   8'h00);
    check("arst_short", 8'(short_flag), 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
